// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning HI/LO with fixed multi-cycle latency
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        mf_sel_E,
  input  logic        d_is_md,
  output logic [31:0] mf_out_E,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic          start;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   divisor, abs_a, abs_b, uq, ur, sq, sr;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;
  logic [CW-1:0] res_cnt;

  // Arithmetic results; signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    prod_s  = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
    prod_u  = {32'b0, rs_E} * {32'b0, rt_E};
    divisor = (rt_E == 32'd0) ? 32'd1 : rt_E;
    abs_a   = rs_E[31] ? (32'd0 - rs_E) : rs_E;
    abs_b   = divisor[31] ? (32'd0 - divisor) : divisor;
    uq      = abs_a / abs_b;
    ur      = abs_a % abs_b;
    sq      = (rs_E[31] ^ divisor[31]) ? (32'd0 - uq) : uq;
    sr      = rs_E[31] ? (32'd0 - ur) : ur;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_wr  = 1'b0;
    res_cnt = MULT_N;
    case (md_op_E)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
      OP_DIV:   begin res_hi = sr; res_lo = sq; res_wr = (rt_E != 32'd0); res_cnt = DIV_N; end
      OP_DIVU:  begin
        res_hi  = rs_E % divisor;
        res_lo  = rs_E / divisor;
        res_wr  = (rt_E != 32'd0);
        res_cnt = DIV_N;
      end
      default: ;
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Next-state: start latches the result, the 1->0 count edge commits it,
  // and any MDU op arriving while busy is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BUSY;
          cnt_d     = res_cnt;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = res_wr;
        end else if (md_op_E == OP_MTHI) begin
          hi_d = rs_E;
        end else if (md_op_E == OP_MTLO) begin
          lo_d = rs_E;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d   = IDLE;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: busy tracks the registered state, reads come from committed regs.
  always_comb begin
    busy     = (state_q == BUSY);
    start    = (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU) && !busy;
    md_stall = d_is_md && (start || busy);
    hi       = hi_q;
    lo       = lo_q;
    mf_out_E = mf_sel_E ? hi_q : lo_q;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline. It consumes the operand and control fields registered by the D/E pipeline register and owns the architectural HI/LO registers. It models fixed multi-cycle latency for mult/multu/div/divu and supports mthi/mtlo writes and mfhi/mflo reads. It drives a stall request to the hazard unit so that a dependent MDU instruction in Decode waits while the unit is busy.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
md_op_E  in  3  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
rs_E  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
rt_E  in  32  forwarded rt value (divisor / multiplier)
mf_sel_E  in  1  read select: 0 LO, 1 HI
d_is_md  in  1  instruction in Decode is any MDU op (mult..mtlo, mfhi, mflo)
mf_out_E  out  32  selected HI/LO value (combinational from committed regs)
busy  out  1  operation in flight
md_stall  out  1  stall request to hazard unit
hi  out  32  committed HI
lo  out  32  committed LO

Behaviour:
- Reset: hi=0, lo=0, busy=0, internal counter=0, pending results=0. Reset mid-operation discards the pending result; HI/LO are not updated.
- States: IDLE (cnt==0) and BUSY (cnt!=0); busy = (cnt!=0), registered.
- start = (md_op_E in 1..4) & ~busy.
- On start edge: compute result from rs_E/rt_E, hold it in pending_hi/pending_lo, and load cnt with MULT_CYCLES or DIV_CYCLES.
- While BUSY: cnt decrements by 1 each edge. On the edge where cnt goes 1->0, hi/lo load the pending values. busy is high for exactly N cycles after the start edge, and new HI/LO are visible in the first cycle busy=0.
- mult: signed 32x32->64; hi = [63:32], lo = [31:0]. multu: same, unsigned.
- div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divisor == 0 (div/divu): still busy for DIV_CYCLES; at completion hi/lo are left unchanged.
- mthi/mtlo when ~busy: hi (or lo) <= rs_E at that edge; single cycle, no busy.
- mthi/mtlo or mult/div arriving while busy: ignored. The hazard unit guarantees this cannot occur; the verification bench flags it as an assertion.
- mf_out_E = mf_sel_E ? hi : lo, combinational. There is no bypass of the pending result; md_stall prevents early reads.
- md_stall = d_is_md & (start | busy), combinational.
- Bubbles from the D/E register carry md_op_E=0 and cause no action.

Test Plan:
- mult rs=0xFFFFFFFF rt=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu rs=0xFFFFFFFF rt=0x00000002 -> after 5 cycles: hi=0x00000001, lo=0xFFFFFFFE. During busy, mf_out_E still shows the old HI/LO.
- div rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 div 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu rs=7 rt=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi/lo remain 0x11/0x22.
- d_is_md=1 in the start cycle and through busy -> md_stall=1 for 1+N cycles and 0 on the cycle busy falls. d_is_md=0 -> md_stall=0 throughout.
- mthi rs=0xDEADBEEF then mtlo rs=0x12345678 -> hi/lo update on the next edge with no busy. Then start div and assert reset on busy cycle 4 -> hi=lo=0, busy=0 next cycle, and no later commit occurs.
